// File: rtl/matrix_frame_sequencer.sv
// ============================================================================
// Module      : matrix_frame_sequencer
// Description : Packet source for a 4-device MAX7219 chain. It sends the
//               configuration packets, then refreshes the eight rows from a
//               32-byte framebuffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_frame_sequencer #(
    parameter logic [3:0] INTENSITY   = 4'h8,
    parameter int         REFRESH_GAP = 16
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        reinit,
    output logic [63:0] pkt_data,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic        init_done,
    output logic [2:0]  row_idx
);

    typedef enum logic [1:0] {
        ST_CFG = 2'd0,
        ST_ROW = 2'd1,
        ST_GAP = 2'd2
    } state_t;

    localparam logic [63:0] CFG0_PKT = {4{16'h0900}};

    state_t      state;
    logic [2:0]  cfg_k;
    logic [15:0] gap_cnt;
    logic        reinit_pend;
    logic [7:0]  fb [32];

    logic        xfer;
    logic        restart;
    logic [2:0]  row_sel;
    logic [2:0]  cfg_sel;
    logic [63:0] row_pkt;
    logic [63:0] cfg_pkt;

    function automatic logic [15:0] cfg_word(input logic [2:0] idx);
        case (idx)
            3'd0:    cfg_word = 16'h0900;
            3'd1:    cfg_word = {8'h0A, 4'h0, INTENSITY};
            3'd2:    cfg_word = 16'h0B07;
            3'd3:    cfg_word = 16'h0C01;
            default: cfg_word = 16'h0F00;
        endcase
    endfunction

    assign xfer    = pkt_valid && pkt_ready;
    assign restart = reinit_pend && ((state == ST_GAP) || xfer);

    // Next packet candidates: the row or config step that follows the current one.
    always_comb begin
        row_sel = (state == ST_ROW) ? 3'(row_idx + 3'd1) : 3'd0;
        cfg_sel = pkt_valid ? 3'(cfg_k + 3'd1) : cfg_k;
        cfg_pkt = {4{cfg_word(cfg_sel)}};
        row_pkt = '0;
        for (int d = 0; d < 4; d++) begin
            row_pkt[16*d +: 16] = {({5'b0, row_sel} + 8'd1), fb[{2'(d), row_sel}]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                fb[i] <= 8'h00;
            end
        end else if (wr_en) begin
            fb[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_CFG;
            cfg_k       <= 3'd0;
            row_idx     <= 3'd0;
            gap_cnt     <= 16'd0;
            pkt_data    <= 64'd0;
            pkt_valid   <= 1'b0;
            init_done   <= 1'b0;
            reinit_pend <= 1'b0;
        end else begin
            if (restart) begin
                state       <= ST_CFG;
                cfg_k       <= 3'd0;
                row_idx     <= 3'd0;
                pkt_data    <= CFG0_PKT;
                pkt_valid   <= 1'b1;
                init_done   <= 1'b0;
                reinit_pend <= 1'b0;
            end else begin
                case (state)
                    ST_CFG: begin
                        if (!pkt_valid) begin
                            pkt_data  <= cfg_pkt;
                            pkt_valid <= 1'b1;
                        end else if (xfer) begin
                            if (cfg_k == 3'd4) begin
                                state     <= ST_ROW;
                                cfg_k     <= 3'd0;
                                row_idx   <= 3'd0;
                                pkt_data  <= row_pkt;
                                init_done <= 1'b1;
                            end else begin
                                cfg_k    <= 3'(cfg_k + 3'd1);
                                pkt_data <= cfg_pkt;
                            end
                        end
                    end
                    ST_ROW: begin
                        if (xfer) begin
                            if ((row_idx == 3'd7) && (REFRESH_GAP > 0)) begin
                                state     <= ST_GAP;
                                pkt_valid <= 1'b0;
                                row_idx   <= 3'd0;
                                gap_cnt   <= 16'(REFRESH_GAP - 1);
                            end else begin
                                row_idx  <= row_sel;
                                pkt_data <= row_pkt;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == 16'd0) begin
                            state     <= ST_ROW;
                            row_idx   <= 3'd0;
                            pkt_data  <= row_pkt;
                            pkt_valid <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 16'd1;
                        end
                    end
                    default: begin
                        state <= ST_CFG;
                        cfg_k <= 3'd0;
                    end
                endcase
            end
            // A request arriving on the same edge as a restart stays pending.
            if (reinit) begin
                reinit_pend <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_matrix_frame_sequencer.sv
// ============================================================================
// Module      : tb_matrix_frame_sequencer
// Description : Directed bench for matrix_frame_sequencer with a packet-stream
//               model compared on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_frame_sequencer;

    localparam int GAP = 16;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b1;
    logic        wr_en  = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [7:0]  wr_data = 8'd0;
    logic        reinit = 1'b0;
    logic        pkt_ready = 1'b1;
    logic [63:0] pkt_data;
    logic        pkt_valid;
    logic        init_done;
    logic [2:0]  row_idx;

    int n_vec = 0;
    int n_err = 0;

    matrix_frame_sequencer #(
        .INTENSITY   (4'h8),
        .REFRESH_GAP (GAP)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .reinit    (reinit),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .init_done (init_done),
        .row_idx   (row_idx)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: stream position 0..4 = config, 5..12 = rows 0..7, 13 = gap.
    logic [15:0] cfg_tab [5] = '{16'h0900, 16'h0A08, 16'h0B07, 16'h0C01, 16'h0F00};
    logic [7:0]  mfb [32];
    int          m_pos = 0;
    int          m_gap = 0;
    bit          m_valid = 0;
    bit          m_init = 0;
    bit          m_pend = 0;
    bit          m_restart = 0;
    logic [63:0] m_data = '0;

    function automatic logic [63:0] exp_pkt(input int pos);
        logic [63:0] v;
        int r;
        if (pos < 5) begin
            v = {4{cfg_tab[pos]}};
        end else begin
            r = pos - 5;
            for (int d = 0; d < 4; d++) begin
                v[16*d +: 16] = {8'(r + 1), mfb[d*8 + r]};
            end
        end
        return v;
    endfunction

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_gap = 0; m_valid = 0; m_init = 0; m_pend = 0; m_data = '0;
            for (int i = 0; i < 32; i++) mfb[i] = 8'h00;
        end else begin
            m_restart = 0;
            if (m_pos == 13) begin
                if (m_pend) m_restart = 1;
                else begin
                    m_gap = m_gap - 1;
                    if (m_gap == 0) begin
                        m_pos = 5; m_valid = 1; m_data = exp_pkt(5);
                    end
                end
            end else if (!m_valid) begin
                m_valid = 1; m_data = exp_pkt(m_pos);
            end else if (pkt_ready) begin
                if (m_pend) m_restart = 1;
                else if (m_pos == 12 && GAP > 0) begin
                    m_pos = 13; m_valid = 0; m_gap = GAP;
                end else begin
                    m_pos = (m_pos == 12) ? 5 : m_pos + 1;
                    if (m_pos == 5) m_init = 1;
                    m_data = exp_pkt(m_pos);
                end
            end
            if (m_restart) begin
                m_pos = 0; m_valid = 1; m_data = exp_pkt(0); m_init = 0; m_pend = 0;
            end
            if (reinit) m_pend = 1;
            if (wr_en) mfb[wr_addr] = wr_data;
        end
    end

    always @(negedge clk_in) begin
        check("valid", 64'(pkt_valid), 64'(m_valid));
        check("init_done", 64'(init_done), 64'(m_init));
        check("row_idx", 64'(row_idx), (m_pos >= 5 && m_pos <= 12) ? 64'(m_pos - 5) : 64'd0);
        if (m_valid) check("pkt_data", pkt_data, m_data);
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_row(input logic [2:0] r);
        bit hit;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (pkt_valid && init_done && row_idx == r) hit = 1;
        end
        check("wait_row_timeout", 64'(hit), 64'd1);
    endtask

    int cnt;

    initial begin
        #1 rst_n = 1'b0;
        tick(); tick();
        check("rst_valid", 64'(pkt_valid), 64'd0);
        check("rst_data", pkt_data, 64'd0);
        check("rst_init", 64'(init_done), 64'd0);
        check("rst_row", 64'(row_idx), 64'd0);

        // Configuration burst then row 0.
        rst_n = 1'b1;
        tick(); check("cfg0", pkt_data, 64'h0900_0900_0900_0900);
        check("cfg0_valid", 64'(pkt_valid), 64'd1);
        tick(); check("cfg1", pkt_data, 64'h0A08_0A08_0A08_0A08);
        tick(); check("cfg2", pkt_data, 64'h0B07_0B07_0B07_0B07);
        tick(); check("cfg3", pkt_data, 64'h0C01_0C01_0C01_0C01);
        check("cfg3_init", 64'(init_done), 64'd0);
        tick(); check("cfg4", pkt_data, 64'h0F00_0F00_0F00_0F00);
        tick(); check("row0", pkt_data, 64'h0100_0100_0100_0100);
        check("row0_init", 64'(init_done), 64'd1);

        // Framebuffer writes while row 0 is stalled.
        pkt_ready = 1'b0;
        wr_en = 1'b1; wr_addr = 5'b11_010; wr_data = 8'hAA;
        tick();
        wr_addr = 5'b00_010; wr_data = 8'h55;
        tick();
        wr_en = 1'b0; pkt_ready = 1'b1;
        tick(); tick();
        check("row2", pkt_data, 64'h03AA_0300_0300_0355);
        check("row2_idx", 64'(row_idx), 64'd2);

        // Refresh gap length and frame period.
        wait_row(3'd7);
        tick();
        cnt = 0;
        while (!pkt_valid && cnt < 100) begin
            cnt++;
            tick();
        end
        check("gap_len", 64'(cnt), 64'd16);
        check("gap_row0", pkt_data, 64'h0100_0100_0100_0100);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!(pkt_valid && row_idx == 3'd0) && cnt < 100);
        check("period", 64'(cnt), 64'd24);

        // Ten-cycle stall on row 3 with a write to that row.
        tick(); tick(); tick();
        pkt_ready = 1'b0;
        check("stall_row", 64'(row_idx), 64'd3);
        for (int i = 0; i < 10; i++) begin
            wr_en = (i == 2);
            wr_addr = 5'b01_011; wr_data = 8'h3C;
            tick();
            check("stall_data", pkt_data, 64'h0400_0400_0400_0400);
            check("stall_valid", 64'(pkt_valid), 64'd1);
        end
        wr_en = 1'b0; pkt_ready = 1'b1;
        wait_row(3'd3);
        check("row3_new", pkt_data, 64'h0400_0400_043C_0400);

        // reinit during a stalled row 4.
        wait_row(3'd4);
        pkt_ready = 1'b0;
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        tick(); tick();
        check("reinit_hold", pkt_data, 64'h0500_0500_0500_0500);
        check("reinit_hold_init", 64'(init_done), 64'd1);
        pkt_ready = 1'b1;
        tick();
        check("reinit_cfg0", pkt_data, 64'h0900_0900_0900_0900);
        check("reinit_init", 64'(init_done), 64'd0);
        repeat (5) tick();
        check("reinit_row0", pkt_data, 64'h0100_0100_0100_0100);
        check("reinit_row0_init", 64'(init_done), 64'd1);
        tick(); tick();
        check("retain_row2", pkt_data, 64'h03AA_0300_0300_0355);
        tick();
        check("retain_row3", pkt_data, 64'h0400_0400_043C_0400);

        // Asynchronous reset during config step 2.
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("pre_rst_cfg2", pkt_data, 64'h0B07_0B07_0B07_0B07);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 64'(pkt_valid), 64'd0);
        check("async_data", pkt_data, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("restart_cfg0", pkt_data, 64'h0900_0900_0900_0900);
        tick();
        check("restart_cfg1", pkt_data, 64'h0A08_0A08_0A08_0A08);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/matrix_frame_sequencer.md
# matrix_frame_sequencer

Upstream packet source for the 4-device MAX7219 LED-matrix chain. Holds a 32-byte framebuffer (4 devices × 8 rows) written by the application. After reset it emits the five configuration packets, then refreshes rows 1..8 continuously. Each 64-bit packet is handed over a valid/ready handshake to the SPI serializer stage, which shifts it out MSB first under one chip-select frame.

## Interface
- INTENSITY, 4'h8: data byte for register 0x0A in the intensity packet.
- REFRESH_GAP, 16: idle cycles between row-8 acceptance and the row-1 packet; 0 means back-to-back.
- clk_in  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- wr_en  input  1  framebuffer write strobe.
- wr_addr  input  5  {device[1:0], row[2:0]}; row 0..7 maps to MAX7219 digit register 0x01..0x08.
- wr_data  input  8  byte to store.
- reinit  input  1  single-cycle request to replay the configuration sequence.
- pkt_data  output  64  packet {dev3, dev2, dev1, dev0}, 16 bits each as {addr[7:0], data[7:0]}; bit 63 is shifted first.
- pkt_valid  output  1  pkt_data is valid.
- pkt_ready  input  1  serializer accepts; a transfer occurs on an edge where pkt_valid && pkt_ready.
- init_done  output  1  high once all five config packets have been accepted.
- row_idx  output  3  row (0..7) of the current row packet; 0 during config.

## Operation
- States:
  - CFG: packets k = 0..4.
  - ROW: r = 0..7.
  - GAP: idle.
- Config packets carry the same 16-bit word repeated ×4:
  - k0 = 16'h0900 (no decode)
  - k1 = {8'h0A, 4'h0, INTENSITY}
  - k2 = 16'h0B07 (scan 8 rows)
  - k3 = 16'h0C01 (normal operation)
  - k4 = 16'h0F00 (display test off)
- Row packet r: for each device d, word = {8'(r+1), fb[d][r]}. Device 3's word occupies bits 63:48.
- Transitions, each on a transfer edge:
  - CFG k → CFG k+1.
  - CFG 4 → ROW 0, and init_done is set.
  - ROW r → ROW r+1.
  - ROW 7 → GAP when REFRESH_GAP > 0; otherwise ROW 0.
  - GAP → ROW 0 after REFRESH_GAP cycles.
- Packet load: pkt_data is loaded on the same edge that enters a state, snapshotting the framebuffer at that edge. pkt_data is held constant while pkt_valid is high and not accepted.
- Framebuffer: register array, reset to 8'h00. A write on edge t updates the byte at t. A packet loaded on edge t carries the pre-write value (read-before-write).
- reinit: sets a sticky pending flag.
  - In CFG/ROW: at the next transfer edge, the state goes to CFG 0 instead of its normal successor, init_done clears, and the flag clears.
  - In GAP: the state goes to CFG 0 on the next edge.
  - Framebuffer contents are preserved.
- Counters: the 16-bit gap counter loads REFRESH_GAP-1 on entry and counts down to 0. row_idx and k wrap 7→0 and 4→0 only via the transitions above.

## Timing
- Reset values:
  - pkt_valid = 0
  - pkt_data = 0
  - init_done = 0
  - row_idx = 0
  - framebuffer all 0
  - state = CFG 0
  - reinit flag = 0
- First rising edge after rst_n deasserts: pkt_data = 64'h0900_0900_0900_0900, pkt_valid = 1.
- Zero-bubble: when pkt_ready is held high, one packet is transferred per cycle during CFG and ROW. pkt_valid stays high across the transfer edge while the next packet loads.
- GAP: pkt_valid = 0 for exactly REFRESH_GAP cycles.
- pkt_valid never drops without a transfer, except on reset.
- init_done rises on the edge that accepts k4, the same edge that loads row 0.
- rst_n assertion mid-packet: all outputs go to reset values immediately (asynchronous). The serializer must abort its frame.

## Test plan
- Reset release, pkt_ready = 1 → five packets:
  - 0900×4
  - 0A08×4
  - 0B07×4
  - 0C01×4
  - 0F00×4
  
  Then row 0 = 64'h0100_0100_0100_0100 with init_done high on that cycle.
- Write fb[3][2] = 8'hAA, fb[0][2] = 8'h55 → row-2 packet is 64'h03AA_0300_0300_0355 with row_idx = 2.
- REFRESH_GAP = 16, pkt_ready = 1 → after row-7 acceptance, pkt_valid is low 16 cycles, then row 0 is presented; period is 8 + 16 = 24 cycles.
- pkt_ready low for 10 cycles mid-ROW, with a write to the held row during the stall → pkt_data and pkt_valid are stable throughout. The new byte appears on that row's next visit.
- Pulse reinit during ROW 4 with pkt_ready = 0 → ROW 4 is still transferred when ready rises, then CFG 0 follows and init_done drops. The framebuffer is retained in later row packets.
- Assert rst_n low during CFG 2 → pkt_valid drops asynchronously. After release, the sequence restarts at 0900×4.
